// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall, flush and forwarding control with memory-wait timeout.
// Define HAZARD_PERF_EN to build the saturating performance counters.
module hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int TIMEOUT      = 255,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  ex_valid,
    input  logic                  ex_we,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_valid,
    input  logic                  mem_we,
    input  logic                  mem_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_valid,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  br_taken,
    input  logic                  mem_busy,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  stall_ex,
    output logic                  stall_mem,
    output logic                  bubble_ex,
    output logic                  bubble_wb,
    output logic                  flush_ifid,
    output logic                  flush_idex,
    output logic                  flush_exmem,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  err_timeout,
    output logic [CNT_W-1:0]      perf_stall_cnt,
    output logic [CNT_W-1:0]      perf_flush_cnt,
    output logic [CNT_W-1:0]      perf_wait_cnt
);
    localparam logic [1:0] RUN = 2'd0, FLUSH = 2'd1, MEM_WAIT = 2'd2;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic [1:0] FLUSH_LEFT = 2'(FLUSH_CYCLES - 1);

    logic [1:0] state_q, state_d, fcnt_q, fcnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic err_q, err_d;
    logic br_acc, flush_tail, load_use, lu_acc, mem_fwd, wb_fwd;
    logic unused_ex_we;

    assign unused_ex_we = ex_we;

    always_comb begin
        br_acc     = br_taken & ~mem_busy;
        flush_tail = (state_q == FLUSH) & ~mem_busy;
        load_use   = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                     ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
        // a flushed ID instruction is discarded, so it cannot cause a load-use stall
        lu_acc     = load_use & ~mem_busy & ~br_acc & ~flush_tail;
        wait_inc   = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
        wait_d     = mem_busy ? wait_inc : '0;
        err_d      = err_q | (mem_busy & (wait_inc == WAIT_MAX));
        state_d    = RUN;
        fcnt_d     = fcnt_q;
        if (mem_busy) begin
            state_d = MEM_WAIT;
        end else if (br_taken) begin
            state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            fcnt_d  = FLUSH_LEFT;
        end else if (state_q == FLUSH) begin
            state_d = (fcnt_q == 2'd1) ? RUN : FLUSH;
            fcnt_d  = fcnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign stall_if    = ~reset & (mem_busy | lu_acc);
    assign stall_id    = ~reset & (mem_busy | lu_acc);
    assign stall_ex    = ~reset & mem_busy;
    assign stall_mem   = ~reset & mem_busy;
    assign bubble_ex   = ~reset & lu_acc;
    assign bubble_wb   = ~reset & mem_busy;
    assign flush_ifid  = ~reset & (br_acc | flush_tail);
    assign flush_idex  = ~reset & br_acc;
    assign flush_exmem = ~reset & br_acc;
    assign err_timeout = err_q;

    // a nonzero destination match excludes register 0 from forwarding
    always_comb begin
        mem_fwd   = mem_valid & mem_we & ~mem_mem_read & (mem_rd != '0);
        wb_fwd    = wb_valid & wb_we & (wb_rd != '0);
        fwd_a_sel = (mem_fwd & (mem_rd == ex_rs1)) ? 2'b01 : (wb_fwd & (wb_rd == ex_rs1)) ? 2'b10 : 2'b00;
        fwd_b_sel = (mem_fwd & (mem_rd == ex_rs2)) ? 2'b01 : (wb_fwd & (wb_rd == ex_rs2)) ? 2'b10 : 2'b00;
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, wait_cnt_q, wait_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(lu_acc & (stall_cnt_q != '1));
        flush_cnt_d = flush_cnt_q + CNT_W'(br_acc & (flush_cnt_q != '1));
        wait_cnt_d  = wait_cnt_q + CNT_W'(mem_busy & (wait_cnt_q != '1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
    assign perf_wait_cnt  = wait_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
    assign perf_wait_cnt  = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table vectors, directed multi-cycle sequences and random stimulus against a reference model.
module tb_hazard_ctrl;
    localparam int FC = 3;
    localparam int TO = 8;
    localparam int CW = 16;

    typedef struct packed {
        logic       id_valid, id_rs1_used, id_rs2_used;
        logic [4:0] id_rs1, id_rs2;
        logic       ex_valid, ex_we, ex_mem_read;
        logic [4:0] ex_rs1, ex_rs2, ex_rd;
        logic       mem_valid, mem_we, mem_mem_read;
        logic [4:0] mem_rd;
        logic       wb_valid, wb_we;
        logic [4:0] wb_rd;
        logic       br_taken, mem_busy;
    } in_t;

    typedef struct packed {
        logic       stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb;
        logic       flush_ifid, flush_idex, flush_exmem;
        logic [1:0] fa, fb;
        logic       err;
    } out_t;

    typedef struct {
        in_t   i;
        out_t  o;
        string n;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    in_t vi = '0;
    logic stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb;
    logic flush_ifid, flush_idex, flush_exmem, err_timeout;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [CW-1:0] perf_stall_cnt, perf_flush_cnt, perf_wait_cnt;
    out_t dut_o;
    logic [8:0] ctrl;

    int checks = 0, errors = 0;
    int flush_left = 0, wait_m = 0, p_stall = 0, p_flush = 0, p_wait = 0;
    logic err_m = 1'b0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(FC), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(vi.id_valid), .id_rs1_used(vi.id_rs1_used), .id_rs2_used(vi.id_rs2_used),
        .id_rs1(vi.id_rs1), .id_rs2(vi.id_rs2),
        .ex_valid(vi.ex_valid), .ex_we(vi.ex_we), .ex_mem_read(vi.ex_mem_read),
        .ex_rs1(vi.ex_rs1), .ex_rs2(vi.ex_rs2), .ex_rd(vi.ex_rd),
        .mem_valid(vi.mem_valid), .mem_we(vi.mem_we), .mem_mem_read(vi.mem_mem_read), .mem_rd(vi.mem_rd),
        .wb_valid(vi.wb_valid), .wb_we(vi.wb_we), .wb_rd(vi.wb_rd),
        .br_taken(vi.br_taken), .mem_busy(vi.mem_busy),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .bubble_ex(bubble_ex), .bubble_wb(bubble_wb),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .err_timeout(err_timeout),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt), .perf_wait_cnt(perf_wait_cnt)
    );

    assign ctrl  = {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb, flush_ifid, flush_idex, flush_exmem};
    assign dut_o = {ctrl, fwd_a_sel, fwd_b_sel, err_timeout};

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic is_load_use(input in_t v);
        return v.ex_valid && v.ex_mem_read && v.ex_rd != 0 && v.id_valid &&
               ((v.id_rs1_used && v.id_rs1 == v.ex_rd) || (v.id_rs2_used && v.id_rs2 == v.ex_rd));
    endfunction

    function automatic logic [1:0] fwd_ref(input in_t v, input logic [4:0] src);
        if (src == 0) return 2'b00;
        if (v.mem_valid && v.mem_we && !v.mem_mem_read && v.mem_rd == src) return 2'b01;
        if (v.wb_valid && v.wb_we && v.wb_rd == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic out_t model_out(input in_t v);
        out_t o;
        logic busy, br, fl, lu;
        busy = v.mem_busy;
        br   = v.br_taken && !busy;
        fl   = br || (flush_left > 0 && !busy);
        lu   = is_load_use(v) && !busy && !fl;
        o.stall_if = busy || lu;
        o.stall_id = busy || lu;
        o.stall_ex = busy;
        o.stall_mem = busy;
        o.bubble_ex = lu;
        o.bubble_wb = busy;
        o.flush_ifid = fl;
        o.flush_idex = br;
        o.flush_exmem = br;
        o.fa = fwd_ref(v, v.ex_rs1);
        o.fb = fwd_ref(v, v.ex_rs2);
        o.err = err_m;
        return o;
    endfunction

    task automatic model_update(input in_t v);
        logic fl;
        fl = !v.mem_busy && (v.br_taken || flush_left > 0);
        if (v.mem_busy) begin
            wait_m++;
            if (wait_m >= TO) err_m = 1'b1;
            flush_left = 0;
            p_wait++;
        end else begin
            if (is_load_use(v) && !fl) p_stall++;
            wait_m = 0;
            if (v.br_taken) begin
                flush_left = FC - 1;
                p_flush++;
            end else if (flush_left > 0) flush_left--;
        end
    endtask

    task automatic model_reset();
        flush_left = 0; wait_m = 0; err_m = 1'b0;
        p_stall = 0; p_flush = 0; p_wait = 0;
    endtask

    task automatic drive(input in_t v, input string n);
        vi = v;
        #1;
        check(n, 32'(dut_o), 32'(model_out(v)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update(vi);
        #1;
    endtask

    task automatic do_reset(input string n);
        reset = 1'b1;
        #1;
        check({n, "_ctrl"}, 32'(ctrl), 32'd0);
        check({n, "_err"}, 32'(err_timeout), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic add_vec(input in_t i, input out_t o, input string n);
        vec_t v;
        v.i = i; v.o = o; v.n = n;
        tbl.push_back(v);
    endtask

    initial begin
        in_t t, idle, lu_in;
        out_t e;
        logic [2:0] fexp [4];
        logic [CW-1:0] w0;
        fexp[0] = 3'b111; fexp[1] = 3'b100; fexp[2] = 3'b100; fexp[3] = 3'b000;
        idle = '0;
        lu_in = '0;
        lu_in.id_valid = 1; lu_in.id_rs1_used = 1; lu_in.id_rs1 = 5;
        lu_in.ex_valid = 1; lu_in.ex_we = 1; lu_in.ex_mem_read = 1; lu_in.ex_rd = 5;

        t = '0; e = '0; t = lu_in; e.stall_if = 1; e.stall_id = 1; e.bubble_ex = 1;
        add_vec(t, e, "lw_use_rs1");
        t = '0; e = '0; t.ex_valid = 1; t.ex_rs1 = 5; t.ex_rd = 6; t.wb_valid = 1; t.wb_we = 1; t.wb_rd = 5; e.fa = 2'b10;
        add_vec(t, e, "fwd_a_wb_after_lw");
        t = '0; e = '0; t.mem_valid = 1; t.mem_we = 1; t.mem_rd = 3; t.wb_valid = 1; t.wb_we = 1; t.wb_rd = 3; t.ex_rs2 = 3; e.fb = 2'b01;
        add_vec(t, e, "fwd_b_mem_priority");
        t = '0; e = '0; t.mem_valid = 1; t.mem_we = 1; t.mem_rd = 0; t.wb_valid = 1; t.wb_we = 1; t.wb_rd = 0;
        add_vec(t, e, "fwd_x0_never");
        t = '0; e = '0; t.mem_valid = 1; t.mem_we = 1; t.mem_mem_read = 1; t.mem_rd = 7; t.wb_valid = 1; t.wb_we = 1; t.wb_rd = 7; t.ex_rs1 = 7; e.fa = 2'b10;
        add_vec(t, e, "fwd_load_in_mem_skipped");
        t = '0; e = '0; t.mem_we = 1; t.mem_rd = 4; t.wb_valid = 1; t.wb_we = 1; t.wb_rd = 4; t.ex_rs1 = 4; t.ex_rs2 = 4; e.fa = 2'b10; e.fb = 2'b10;
        add_vec(t, e, "fwd_mem_invalid");
        t = '0; e = '0; t.mem_valid = 1; t.mem_we = 1; t.mem_rd = 2; t.wb_valid = 1; t.wb_rd = 1; t.ex_rs1 = 1; t.ex_rs2 = 2; e.fb = 2'b01;
        add_vec(t, e, "fwd_wb_no_we");
        t = lu_in; t.ex_rd = 0; t.id_rs1 = 0; e = '0;
        add_vec(t, e, "lu_x0_no_stall");
        t = lu_in; t.ex_rd = 9; t.id_rs1_used = 0; t.id_rs1 = 9; t.id_rs2_used = 1; t.id_rs2 = 9; e = '0; e.stall_if = 1; e.stall_id = 1; e.bubble_ex = 1;
        add_vec(t, e, "lu_rs2");
        t = lu_in; t.id_rs1_used = 0; t.id_rs2 = 5; e = '0;
        add_vec(t, e, "lu_unused_src");
        t = lu_in; t.id_valid = 0; e = '0;
        add_vec(t, e, "lu_id_invalid");
        t = lu_in; t.ex_mem_read = 0; e = '0;
        add_vec(t, e, "lu_not_load");

        t = lu_in; t.br_taken = 1; t.mem_busy = 1; vi = t;
        #2;
        check("reset_hold_ctrl", 32'(ctrl), 32'd0);
        check("reset_hold_err", 32'(err_timeout), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        foreach (tbl[k]) begin
            vi = tbl[k].i;
            #1;
            check(tbl[k].n, 32'(dut_o), 32'(tbl[k].o));
            tick();
        end

        for (int k = 0; k < 4; k++) begin
            t = lu_in; t.br_taken = (k == 0);
            drive(t, "flush_seq_model");
            check("flush_seq_pattern", 32'({flush_ifid, flush_idex, flush_exmem}), 32'(fexp[k]));
            check("flush_seq_lu_stall", 32'(stall_if), 32'(k == 3));
            tick();
        end

        for (int k = 0; k < 5; k++) begin
            t = idle; t.br_taken = (k < 2);
            drive(t, "flush_restart_model");
            check("flush_restart_ifid", 32'(flush_ifid), 32'(k < 4));
            tick();
        end

        w0 = perf_wait_cnt;
        for (int k = 0; k < 5; k++) begin
            t = idle; t.br_taken = 1; t.mem_busy = (k < 4);
            drive(t, "busy_br_model");
            check("busy_br_stall", 32'({stall_if, stall_id, stall_ex, stall_mem, bubble_wb}), (k < 4) ? 32'h1f : 32'h0);
            check("busy_br_flush", 32'({flush_ifid, flush_idex, flush_exmem}), (k < 4) ? 32'h0 : 32'h7);
            tick();
        end
`ifdef HAZARD_PERF_EN
        check("perf_wait_4", 32'(perf_wait_cnt - w0), 32'd4);
`else
        check("perf_off", 32'({perf_stall_cnt, perf_flush_cnt, perf_wait_cnt}), 32'd0);
`endif
        for (int k = 0; k < 2; k++) begin
            drive(idle, "drain_model");
            tick();
        end

        for (int k = 0; k < 10; k++) begin
            t = idle; t.mem_busy = 1;
            drive(t, "timeout_model");
            check("timeout_rise", 32'(err_timeout), 32'(k >= 8));
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(idle, "timeout_sticky_model");
            check("timeout_sticky", 32'(err_timeout), 32'd1);
            tick();
        end
        do_reset("timeout_clear");
        check("timeout_after_reset", 32'(err_timeout), 32'd0);

        t = idle; t.br_taken = 1;
        drive(t, "mid_flush_br");
        tick();
        drive(lu_in, "mid_flush_cycle1");
        check("mid_flush_ifid", 32'(flush_ifid), 32'd1);
        #1;
        do_reset("async_reset");
        drive(lu_in, "after_reset_run");
        check("after_reset_flush", 32'({flush_ifid, flush_idex, flush_exmem}), 32'd0);
        check("after_reset_stall", 32'(stall_if), 32'd1);
        tick();

        for (int k = 0; k < 600; k++) begin
            t.id_valid = 1'($urandom_range(0, 1)); t.id_rs1_used = 1'($urandom_range(0, 1)); t.id_rs2_used = 1'($urandom_range(0, 1));
            t.id_rs1 = 5'($urandom_range(0, 3)); t.id_rs2 = 5'($urandom_range(0, 3));
            t.ex_valid = 1'($urandom_range(0, 1)); t.ex_we = 1'($urandom_range(0, 1)); t.ex_mem_read = 1'($urandom_range(0, 1));
            t.ex_rs1 = 5'($urandom_range(0, 3)); t.ex_rs2 = 5'($urandom_range(0, 3)); t.ex_rd = 5'($urandom_range(0, 3));
            t.mem_valid = 1'($urandom_range(0, 1)); t.mem_we = 1'($urandom_range(0, 1)); t.mem_mem_read = 1'($urandom_range(0, 1));
            t.mem_rd = 5'($urandom_range(0, 3));
            t.wb_valid = 1'($urandom_range(0, 1)); t.wb_we = 1'($urandom_range(0, 1)); t.wb_rd = 5'($urandom_range(0, 3));
            t.br_taken = ($urandom_range(0, 99) < 10);
            t.mem_busy = ($urandom_range(0, 99) < 15);
            drive(t, "random");
            tick();
        end

`ifdef HAZARD_PERF_EN
        check("perf_stall_total", 32'(perf_stall_cnt), 32'(p_stall));
        check("perf_flush_total", 32'(perf_flush_cnt), 32'(p_flush));
        check("perf_wait_total", 32'(perf_wait_cnt), 32'(p_wait));
`else
        check("perf_off_end", 32'({perf_stall_cnt, perf_flush_cnt, perf_wait_cnt}), 32'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
